// File: rtl/std_tpram_sp_arb_if.sv
// -----------------------------------------------------------------------------
// std_tpram_sp_arb_if
// Bundles the read and write request ports of std_tpram_sp_arb.
//   master : drives rceb/raddr and wceb/waddr/wdata, observes rrdy, rdata,
//            rvalid, wrdy and wbuf_cnt
//   slave  : the RAM side of the same signals
// Parameters DW, AW and WBUF_DEPTH must match those of the RAM instance.
// -----------------------------------------------------------------------------
interface std_tpram_sp_arb_if #(
    parameter int DW         = 144,
    parameter int AW         = 6,
    parameter int WBUF_DEPTH = 2
);
    localparam int CW = $clog2(WBUF_DEPTH + 1);

    logic          rceb;
    logic [AW-1:0] raddr;
    logic          rrdy;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          wceb;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          wrdy;
    logic [CW-1:0] wbuf_cnt;

    modport master (
        output rceb, raddr, wceb, waddr, wdata,
        input  rrdy, rdata, rvalid, wrdy, wbuf_cnt
    );

    modport slave (
        input  rceb, raddr, wceb, waddr, wdata,
        output rrdy, rdata, rvalid, wrdy, wbuf_cnt
    );
endinterface

// File: rtl/std_tpram_sp_arb.sv
// -----------------------------------------------------------------------------
// std_tpram_sp_arb
// Two-port RAM behaviour (independent read and write ports, one clock) built
// on a single-port array doing one access per cycle. Writes that collide with
// a read are parked in a small circular FIFO and drained on cycles without an
// accepted read; a full FIFO forces a drain and refuses the read that cycle.
//
// Ports:
//   clk            single clock
//   rst_n          asynchronous active-low reset
//   bus (slave)    rceb/raddr/rrdy/rdata/rvalid : read port, latency 1
//                  wceb/waddr/wdata/wrdy        : write port
//                  wbuf_cnt                     : write-buffer occupancy
//
// Optional feature macro: STD_TPRAM_FWD_EN
//   defined   : reads return the youngest matching buffered write, so read
//               data is coherent with every earlier accepted write
//   undefined : reads see array contents only (buffered writes are invisible
//               until drained)
// -----------------------------------------------------------------------------
module std_tpram_sp_arb #(
    parameter int DW         = 144,
    parameter int AW         = 6,
    parameter int WBUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    std_tpram_sp_arb_if.slave    bus
);
    localparam int CW    = $clog2(WBUF_DEPTH + 1);
    localparam int PW    = $clog2(WBUF_DEPTH);
    localparam int DEPTH = 2 ** AW;

    // Storage: array and write-buffer payload carry no reset.
    logic [DW-1:0] mem_q      [DEPTH];
    logic [AW-1:0] buf_addr_q [WBUF_DEPTH];
    logic [DW-1:0] buf_data_q [WBUF_DEPTH];

    // Control state.
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q,  rdata_d;

    logic          full, empty;
    logic          rd_acc, wr_acc;
    logic          rd_en, pop, push, cut;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    assign full  = (cnt_q == CW'(WBUF_DEPTH));
    assign empty = (cnt_q == '0);

    // Ready depends on registered occupancy only.
    assign bus.rrdy     = !full;
    assign bus.wrdy     = !full;
    assign bus.wbuf_cnt = cnt_q;
    assign bus.rdata    = rdata_q;
    assign bus.rvalid   = rvalid_q;

    assign rd_acc = !bus.rceb && !full;
    assign wr_acc = !bus.wceb && !full;

    // One array access per cycle: forced drain > read > drain > cut-through.
    always_comb begin
        rd_en     = 1'b0;
        pop       = 1'b0;
        cut       = 1'b0;
        mem_waddr = buf_addr_q[head_q];
        mem_wdata = buf_data_q[head_q];
        if (full) begin
            pop = 1'b1;
        end else if (rd_acc) begin
            rd_en = 1'b1;
        end else if (!empty) begin
            pop = 1'b1;
        end else if (wr_acc) begin
            cut       = 1'b1;
            mem_waddr = bus.waddr;
            mem_wdata = bus.wdata;
        end
        push   = wr_acc && !cut;
        // The array has no reset, so block writes while reset is held to keep
        // discarded buffer entries from reaching it.
        mem_we = (pop || cut) && rst_n;
    end

    always_comb begin
        head_d = pop  ? head_q + PW'(1) : head_q;
        tail_d = push ? tail_q + PW'(1) : tail_q;
        cnt_d  = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

`ifdef STD_TPRAM_FWD_EN
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [PW-1:0] fwd_idx;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = head_q;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if ((CW'(i) < cnt_q) && (buf_addr_q[fwd_idx] == bus.raddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data_q[fwd_idx];
            end
        end
    end

    always_comb begin
        rvalid_d = rd_en;
        rdata_d  = rdata_q;
        if (rd_en) begin
            rdata_d = fwd_hit ? fwd_data : mem_q[bus.raddr];
        end
    end
`else
    always_comb begin
        rvalid_d = rd_en;
        rdata_d  = rdata_q;
        if (rd_en) begin
            rdata_d = mem_q[bus.raddr];
        end
    end
`endif

    // ---- register stage: control and read data ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // ---- register stage: buffer payload and array ----
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[tail_q] <= bus.waddr;
            buf_data_q[tail_q] <= bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end
endmodule

// File: tb/tb_std_tpram_sp_arb.sv
module tb_std_tpram_sp_arb;
    localparam int DW = 144;
    localparam int AW = 6;
    localparam int D  = 2;
    localparam int CW = $clog2(D + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    std_tpram_sp_arb_if #(.DW(DW), .AW(AW), .WBUF_DEPTH(D)) bus ();

    std_tpram_sp_arb #(.DW(DW), .AW(AW), .WBUF_DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: array contents plus an ordered list of pending writes.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           q[$];
    logic [DW-1:0] mdl_mem [2**AW];
    logic          exp_rvalid = 1'b0;
    logic [DW-1:0] exp_rdata  = '0;
    bit            racc, wacc;

    int checks = 0;
    int passed = 0;

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r = '0;
        for (int i = 0; i < 5; i++) r = (r << 32) | DW'($urandom());
        return r;
    endfunction

    function automatic logic [DW-1:0] lit(input int v);
        return DW'(v);
    endfunction

    // Drive one cycle of requests and advance the model by the same cycle.
    task automatic cyc(input bit rce, input logic [AW-1:0] ra,
                       input bit wce, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd);
        bit  full, cut;
        wr_t e;
        bus.rceb  = rce;
        bus.raddr = ra;
        bus.wceb  = wce;
        bus.waddr = wa;
        bus.wdata = wd;
        full = (q.size() == D);
        racc = !rce && !full;
        wacc = !wce && !full;
        cut  = 1'b0;
        @(posedge clk);
        if (full) begin
            e = q.pop_front();
            mdl_mem[e.a] = e.d;
        end else if (racc) begin
            exp_rdata = mdl_mem[ra];
`ifdef STD_TPRAM_FWD_EN
            foreach (q[i]) if (q[i].a == ra) exp_rdata = q[i].d;
`endif
        end else if (q.size() != 0) begin
            e = q.pop_front();
            mdl_mem[e.a] = e.d;
        end else if (wacc) begin
            mdl_mem[wa] = wd;
            cut = 1'b1;
        end
        if (wacc && !cut) q.push_back('{a: wa, d: wd});
        exp_rvalid = racc;
        #1;
    endtask

    task automatic idle();
        cyc(1'b1, '0, 1'b1, '0, '0);
    endtask

    task automatic test_reset();
        bus.rceb = 1'b1; bus.raddr = '0;
        bus.wceb = 1'b1; bus.waddr = '0; bus.wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.rdata !== '0) $display("FAIL reset_rdata got %0h want 0", bus.rdata); else passed++;
        checks++; if (bus.rvalid !== 1'b0) $display("FAIL reset_rvalid got %b want 0", bus.rvalid); else passed++;
        checks++; if (bus.wbuf_cnt !== '0) $display("FAIL reset_cnt got %0d want 0", bus.wbuf_cnt); else passed++;
        checks++; if (bus.wrdy !== 1'b1) $display("FAIL reset_wrdy got %b want 1", bus.wrdy); else passed++;
        checks++; if (bus.rrdy !== 1'b1) $display("FAIL reset_rrdy got %b want 1", bus.rrdy); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_cut_through();
        // Fill every address with back-to-back writes; all must cut through.
        for (int a = 0; a < 2**AW; a++) begin
            cyc(1'b1, '0, 1'b0, AW'(a), rnd());
            checks++; if (bus.wbuf_cnt !== '0 || bus.wrdy !== 1'b1)
                $display("FAIL fill_cut addr %0d cnt %0d wrdy %b want cnt 0 wrdy 1", a, bus.wbuf_cnt, bus.wrdy);
            else passed++;
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, '0, 1'b0, AW'(i), lit(32'hA0 + i));
            checks++; if (bus.wbuf_cnt !== '0) $display("FAIL cut_cnt addr %0d got %0d want 0", i, bus.wbuf_cnt); else passed++;
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, AW'(i), 1'b1, '0, '0);
            checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== lit(32'hA0 + i))
                $display("FAIL cut_read addr %0d rvalid %b rdata %0h want 1 %0h", i, bus.rvalid, bus.rdata, 32'hA0 + i);
            else passed++;
            checks++; if (bus.wbuf_cnt !== '0) $display("FAIL cut_read_cnt got %0d want 0", bus.wbuf_cnt); else passed++;
        end
        idle();
        checks++; if (bus.rvalid !== 1'b0 || bus.rdata !== lit(32'hA3))
            $display("FAIL rdata_hold rvalid %b rdata %0h want 0 a3", bus.rvalid, bus.rdata);
        else passed++;
    endtask

    task automatic test_collision();
        cyc(1'b0, AW'(5), 1'b0, AW'(9), lit(32'h55));
        checks++; if (bus.wbuf_cnt !== CW'(1)) $display("FAIL coll_cnt1 got %0d want 1", bus.wbuf_cnt); else passed++;
        checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== exp_rdata)
            $display("FAIL coll_read5 rvalid %b rdata %0h want 1 %0h", bus.rvalid, bus.rdata, exp_rdata);
        else passed++;
        idle();
        checks++; if (bus.wbuf_cnt !== '0) $display("FAIL coll_cnt0 got %0d want 0", bus.wbuf_cnt); else passed++;
        cyc(1'b0, AW'(9), 1'b1, '0, '0);
        checks++; if (bus.rdata !== lit(32'h55)) $display("FAIL coll_read9 got %0h want 55", bus.rdata); else passed++;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] dv [4];
        int wi = 1;
        for (int i = 1; i < 4; i++) dv[i] = rnd();
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, AW'($urandom_range(32, 63)), (wi > 3), AW'(wi), dv[wi > 3 ? 3 : wi]);
            if (wacc) wi++;
            checks++; if (bus.wbuf_cnt !== CW'(q.size()) || bus.rrdy !== (q.size() != D) || bus.wrdy !== (q.size() != D))
                $display("FAIL bp_state k %0d cnt %0d rrdy %b wrdy %b want cnt %0d", k, bus.wbuf_cnt, bus.rrdy, bus.wrdy, q.size());
            else passed++;
            checks++; if (bus.rvalid !== exp_rvalid || bus.rdata !== exp_rdata)
                $display("FAIL bp_read k %0d rvalid %b rdata %0h want %b %0h", k, bus.rvalid, bus.rdata, exp_rvalid, exp_rdata);
            else passed++;
            if (k == 1) begin
                checks++; if (bus.wbuf_cnt !== CW'(2) || bus.wrdy !== 1'b0 || bus.rrdy !== 1'b0)
                    $display("FAIL bp_full cnt %0d wrdy %b rrdy %b want 2 0 0", bus.wbuf_cnt, bus.wrdy, bus.rrdy);
                else passed++;
            end
            if (k == 2) begin
                checks++; if (bus.rvalid !== 1'b0 || bus.wbuf_cnt !== CW'(1) || bus.rrdy !== 1'b1)
                    $display("FAIL bp_drain rvalid %b cnt %0d rrdy %b want 0 1 1", bus.rvalid, bus.wbuf_cnt, bus.rrdy);
                else passed++;
            end
        end
        repeat (3) idle();
        for (int i = 1; i < 4; i++) begin
            cyc(1'b0, AW'(i), 1'b1, '0, '0);
            checks++; if (bus.rdata !== dv[i]) $display("FAIL bp_land addr %0d got %0h want %0h", i, bus.rdata, dv[i]); else passed++;
        end
    endtask

    task automatic test_forwarding();
        logic [AW-1:0] ra [3];
        logic [DW-1:0] wd [2];
        int ri = 0;
        int wi = 0;
        ra[0] = AW'(10); ra[1] = AW'(11); ra[2] = AW'(7);
        wd[0] = lit(32'h11); wd[1] = lit(32'h22);
        for (int k = 0; k < 10 && ri < 3; k++) begin
            cyc(1'b0, ra[ri], (wi > 1), AW'(7), wd[wi > 1 ? 1 : wi]);
            if (wacc) wi++;
            if (racc) ri++;
            checks++; if (bus.rvalid !== exp_rvalid || bus.rdata !== exp_rdata || bus.wbuf_cnt !== CW'(q.size()))
                $display("FAIL fwd_seq k %0d rvalid %b rdata %0h cnt %0d want %b %0h %0d", k, bus.rvalid, bus.rdata, bus.wbuf_cnt, exp_rvalid, exp_rdata, q.size());
            else passed++;
        end
        checks++; if (ri != 3) $display("FAIL fwd_timeout reads accepted %0d want 3", ri); else passed++;
`ifdef STD_TPRAM_FWD_EN
        checks++; if (bus.rdata !== lit(32'h22)) $display("FAIL fwd_hit got %0h want 22", bus.rdata); else passed++;
`else
        checks++; if (bus.rdata !== lit(32'h11)) $display("FAIL fwd_stale got %0h want 11", bus.rdata); else passed++;
`endif
        repeat (3) idle();
        cyc(1'b0, AW'(7), 1'b1, '0, '0);
        checks++; if (bus.rdata !== lit(32'h22)) $display("FAIL fwd_after_drain got %0h want 22", bus.rdata); else passed++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)),
                $urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)), rnd());
            checks++; if (bus.wbuf_cnt !== CW'(q.size()) || bus.rrdy !== (q.size() != D) || bus.wrdy !== (q.size() != D))
                $display("FAIL rand_state k %0d cnt %0d rrdy %b wrdy %b want cnt %0d", k, bus.wbuf_cnt, bus.rrdy, bus.wrdy, q.size());
            else passed++;
            checks++; if (bus.rvalid !== exp_rvalid || bus.rdata !== exp_rdata)
                $display("FAIL rand_read k %0d rvalid %b rdata %0h want %b %0h", k, bus.rvalid, bus.rdata, exp_rvalid, exp_rdata);
            else passed++;
        end
        repeat (3) idle();
        for (int a = 0; a < 8; a++) begin
            cyc(1'b0, AW'(a), 1'b1, '0, '0);
            checks++; if (bus.rdata !== mdl_mem[a]) $display("FAIL rand_final addr %0d got %0h want %0h", a, bus.rdata, mdl_mem[a]); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] old20, old21;
        repeat (3) idle();
        old20 = mdl_mem[20];
        old21 = mdl_mem[21];
        cyc(1'b0, AW'(40), 1'b0, AW'(20), rnd());
        cyc(1'b0, AW'(41), 1'b0, AW'(21), rnd());
        checks++; if (bus.wbuf_cnt !== CW'(2) || bus.rvalid !== 1'b1)
            $display("FAIL rstmid_pre cnt %0d rvalid %b want 2 1", bus.wbuf_cnt, bus.rvalid);
        else passed++;
        bus.rceb = 1'b1;
        bus.wceb = 1'b1;
        #2;
        rst_n = 1'b0;
        q.delete();
        exp_rvalid = 1'b0;
        exp_rdata  = '0;
        #1;
        checks++; if (bus.wbuf_cnt !== '0 || bus.rvalid !== 1'b0 || bus.wrdy !== 1'b1 || bus.rrdy !== 1'b1)
            $display("FAIL rstmid_now cnt %0d rvalid %b wrdy %b rrdy %b want 0 0 1 1", bus.wbuf_cnt, bus.rvalid, bus.wrdy, bus.rrdy);
        else passed++;
        checks++; if (bus.rdata !== '0) $display("FAIL rstmid_rdata got %0h want 0", bus.rdata); else passed++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) idle();
        cyc(1'b0, AW'(20), 1'b1, '0, '0);
        checks++; if (bus.rdata !== old20) $display("FAIL rstmid_discard20 got %0h want %0h", bus.rdata, old20); else passed++;
        cyc(1'b0, AW'(21), 1'b1, '0, '0);
        checks++; if (bus.rdata !== old21) $display("FAIL rstmid_discard21 got %0h want %0h", bus.rdata, old21); else passed++;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cut_through();
        test_collision();
        test_backpressure();
        test_forwarding();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
